// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: difference and borrow-out from a, b and borrow-in.
module full_subtractor (
    output logic bo,
    output logic d,
    input  logic a,
    input  logic b,
    input  logic bi
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE (and never while rst is asserted), out_valid only in DONE.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    count;
    logic             br;
    logic             d_bit;
    logic             bo_bit;

    full_subtractor u_cell (
        .bo (bo_bit),
        .d  (d_bit),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (br)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (count == LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at diff[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            count <= '0;
            br    <= 1'b0;
            diff  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        count <= '0;
                        br    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= bo_bit;
                    if (count != LAST) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE) && !rst;
    assign out_valid  = (state == ST_DONE);
    assign borrow_out = br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks;
    int errors;

    logic [WIDTH:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             borrow;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] ed, input logic eb, input string nm);
        bit ok;
        int cyc;
        wait_ready(ok);
        if (!ok) return;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 4 * WIDTH) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, " latency"}, cyc, WIDTH);
        check({nm, " diff"}, diff, ed);
        check({nm, " borrow"}, borrow_out, eb);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, " out_valid_drop"}, out_valid, 0);
    endtask

    // random phase: driver pushes the model result on every accepted pair
    task automatic drive_random(input int n_ops);
        bit acc;
        int waitc;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        for (int i = 0; i < n_ops; i++) begin
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            a = av;
            b = bv;
            in_valid = 1'b1;
            waitc = 0;
            do begin
                @(negedge clk);
                acc = in_valid && in_ready;
                if (acc) exp_q.push_back({(av < bv), WIDTH'(av - bv)});
                @(posedge clk); #1;
                waitc++;
            end while (!acc && waitc < 100);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL rand_accept_timeout: got 0 expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic monitor_random(input int n_ops, output int got);
        int cyc;
        bit r;
        logic [WIDTH:0] e;
        got = 0;
        cyc = 0;
        while (got < n_ops && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            if (out_valid && r) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected: got %0h expected none", {borrow_out, diff});
                end else begin
                    e = exp_q.pop_front();
                    check("rand_result", {borrow_out, diff}, e);
                end
                got++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int got;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst diff", diff, 0);
        check("rst borrow", borrow_out, 0);
        rst = 1'b0;
        #1;
        check("post_rst in_ready", in_ready, 1);

        // directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));
        end
        check("idle holds diff", diff, 8'hFF);

        // backpressure in DONE; an in_valid pulse must be ignored
        wait_ready(ok);
        a = 8'h5A;
        b = 8'h21;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (WIDTH) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 8'hFF;
                b = 8'h00;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", i), out_valid, 1);
            check($sformatf("bp%0d diff", i), diff, 8'h39);
            check($sformatf("bp%0d borrow", i), borrow_out, 0);
            check($sformatf("bp%0d in_ready", i), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release out_valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp pulse ignored in_ready", in_ready, 1);
        check("bp pulse ignored diff", diff, 8'h39);

        // reset after 4 SHIFT edges
        a = 8'h33;
        b = 8'h11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst diff", diff, 0);
        check("midrst in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst release in_ready", in_ready, 1);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, "after_rst");

        // back-to-back random traffic with random out_ready
        got = 0;
        fork
            drive_random(1000);
            monitor_random(1000, got);
        join
        check("rand count", got, 1000);
        check("rand queue empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
